// File: rtl/mem_access_unit_if.sv
// Bus between the control unit (master) and the memory access unit (slave).
// Carries the request fields, the stack/direct-write controls and the results.
interface mem_access_unit_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_DST  = 4,
    parameter int DST_BITS = 2
);
    logic                       start;
    logic [WIDTH-1:0]           pc;
    logic [WIDTH-1:0]           reg_in;
    logic [1:0]                 MemSrc;
    logic [1:0]                 StackOp;
    logic                       MemRead;
    logic                       MemWrite;
    logic [WIDTH-1:0]           wr_data;
    logic                       dst_en;
    logic [DST_BITS-1:0]        MemDst;
    logic [WIDTH-1:0]           sp_in;
    logic                       sp_load;
    logic                       dw_en;
    logic [DST_BITS-1:0]        dw_sel;
    logic [WIDTH-1:0]           dw_data;
    logic [WIDTH-1:0]           mem_out;
    logic [WIDTH-1:0]           sp_out;
    logic [NUM_DST*WIDTH-1:0]   dst_out;
    logic                       busy;
    logic                       done;

    modport master (
        output start, pc, reg_in, MemSrc, StackOp, MemRead, MemWrite, wr_data,
               dst_en, MemDst, sp_in, sp_load, dw_en, dw_sel, dw_data,
        input  mem_out, sp_out, dst_out, busy, done
    );

    modport slave (
        input  start, pc, reg_in, MemSrc, StackOp, MemRead, MemWrite, wr_data,
               dst_en, MemDst, sp_in, sp_load, dw_en, dw_sel, dw_data,
        output mem_out, sp_out, dst_out, busy, done
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: internal word-addressed RAM, hardware stack
// pointer with push/pop, and a bank of destination registers fed by loads
// or by direct writes. Each request runs IDLE -> ACCESS -> COMPLETE.
module mem_access_unit #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_BITS = 10,
    parameter int               NUM_DST   = 4,
    parameter int               DST_BITS  = 2,
    parameter logic [WIDTH-1:0] SP_RESET  = '0
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  accept;
    logic                  busyDec;
    logic                  doneDec;

    logic [WIDTH-1:0]      ram [DEPTH];
    logic [WIDTH-1:0]      memOut;
    logic [WIDTH-1:0]      spOut;
    logic [WIDTH-1:0]      dstReg [NUM_DST];

    logic [ADDR_BITS-1:0]  effIdx;
    logic [ADDR_BITS-1:0]  capIdx;
    logic [WIDTH-1:0]      capData;
    logic                  capRead;
    logic                  capWrite;
    logic                  capDstEn;
    logic [DST_BITS-1:0]   capDst;
    logic [1:0]            capStack;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic and state decodes for busy/done/accept.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        busyDec   = 1'b0;
        doneDec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                busyDec   = 1'b1;
                stateNext = COMPLETE;
            end
            COMPLETE: begin
                busyDec   = 1'b1;
                doneDec   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // RAM index selection; only the low address bits matter, so SP-1 is
    // formed on the low bits directly (same result mod 2**ADDR_BITS).
    always_comb begin
        effIdx = bus.reg_in[ADDR_BITS-1:0];
        case (bus.StackOp)
            2'b01:   effIdx = spOut[ADDR_BITS-1:0] - ADDR_BITS'(1);
            2'b10:   effIdx = spOut[ADDR_BITS-1:0];
            default: begin
                case (bus.MemSrc)
                    2'b00:   effIdx = bus.pc[ADDR_BITS-1:0];
                    2'b01:   effIdx = spOut[ADDR_BITS-1:0];
                    default: effIdx = bus.reg_in[ADDR_BITS-1:0];
                endcase
            end
        endcase
    end

    // Request capture on entry to ACCESS (uses the pre-load SP).
    always_ff @(posedge clock) begin
        if (reset) begin
            capIdx   <= '0;
            capData  <= '0;
            capRead  <= 1'b0;
            capWrite <= 1'b0;
            capDstEn <= 1'b0;
            capDst   <= '0;
            capStack <= '0;
        end else if (accept) begin
            capIdx   <= effIdx;
            capData  <= bus.wr_data;
            capRead  <= bus.MemRead;
            capWrite <= bus.MemWrite;
            capDstEn <= bus.dst_en;
            capDst   <= bus.MemDst;
            capStack <= bus.StackOp;
        end
    end

    // Stack pointer: load only while idle, push/pop adjust at the end of ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            spOut <= SP_RESET;
        end else if (state == IDLE && bus.sp_load) begin
            spOut <= bus.sp_in;
        end else if (state == ACCESS) begin
            if (capStack == 2'b01)      spOut <= spOut - WIDTH'(1);
            else if (capStack == 2'b10) spOut <= spOut + WIDTH'(1);
        end
    end

    // RAM write port; not reset, but a reset edge blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && state == ACCESS && capWrite) ram[capIdx] <= capData;
    end

    // Read data register; read-first because it samples the pre-write word.
    always_ff @(posedge clock) begin
        if (reset)                         memOut <= '0;
        else if (state == ACCESS && capRead) memOut <= ram[capIdx];
    end

    // Destination bank; the load write-back is assigned last so it wins a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DST; i++) dstReg[i] <= '0;
        end else begin
            if (bus.dw_en && int'(bus.dw_sel) < NUM_DST)
                dstReg[bus.dw_sel] <= bus.dw_data;
            if (state == COMPLETE && capRead && capDstEn && int'(capDst) < NUM_DST)
                dstReg[capDst] <= memOut;
        end
    end

    // Output drive.
    always_comb begin
        bus.dst_out = '0;
        for (int unsigned i = 0; i < NUM_DST; i++)
            bus.dst_out[i*WIDTH +: WIDTH] = dstReg[i];
        bus.mem_out = memOut;
        bus.sp_out  = spOut;
        bus.busy    = busyDec;
        bus.done    = doneDec;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default parameters).
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;
    int   doneCount;

    mem_access_unit_if #(.WIDTH(16), .NUM_DST(4), .DST_BITS(2)) bus ();

    mem_access_unit #(
        .WIDTH(16), .ADDR_BITS(10), .NUM_DST(4), .DST_BITS(2), .SP_RESET(16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] dstAt(input int i);
        return bus.dst_out[i*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        bus.start = 0; bus.pc = '0; bus.reg_in = '0; bus.MemSrc = 2'b00;
        bus.StackOp = 2'b00; bus.MemRead = 0; bus.MemWrite = 0; bus.wr_data = '0;
        bus.dst_en = 0; bus.MemDst = '0; bus.sp_in = '0; bus.sp_load = 0;
        bus.dw_en = 0; bus.dw_sel = '0; bus.dw_data = '0;
    endtask

    task automatic launch();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic memWrite(input logic [15:0] addr, input logic [15:0] data);
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = addr; bus.wr_data = data; bus.MemWrite = 1;
        launch(); tick(); tick();
        clearInputs();
    endtask

    task automatic memRead(input logic [15:0] addr);
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = addr; bus.MemRead = 1;
        launch(); tick(); tick();
        clearInputs();
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1; tick(); tick(); reset = 0;
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        nChecks++; if (bus.mem_out !== 16'h0000) begin nFails++; $display("FAIL reset_mem_out: got %h expected 0000", bus.mem_out); end
        nChecks++; if (bus.sp_out !== 16'h0000) begin nFails++; $display("FAIL reset_sp_out: got %h expected 0000", bus.sp_out); end
        nChecks++; if (bus.dst_out !== 64'h0) begin nFails++; $display("FAIL reset_dst_out: got %h expected 0", bus.dst_out); end
    endtask

    task automatic test_write_read();
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = 16'd1; bus.wr_data = 16'd127; bus.MemWrite = 1;
        launch();
        nChecks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin nFails++; $display("FAIL wr_e0: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
        tick();
        nChecks++; if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin nFails++; $display("FAIL wr_e1: got busy=%b done=%b expected busy=1 done=1", bus.busy, bus.done); end
        tick();
        nChecks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nFails++; $display("FAIL wr_e2: got busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done); end
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = 16'd1; bus.MemRead = 1; bus.dst_en = 1; bus.MemDst = 2'd1;
        launch(); tick();
        nChecks++; if (bus.done !== 1'b1 || bus.mem_out !== 16'd127) begin nFails++; $display("FAIL rd_mem_out: got done=%b mem_out=%h expected done=1 mem_out=007f", bus.done, bus.mem_out); end
        nChecks++; if (dstAt(1) !== 16'h0000) begin nFails++; $display("FAIL rd_dst_early: got %h expected 0000", dstAt(1)); end
        tick();
        nChecks++; if (dstAt(1) !== 16'd127) begin nFails++; $display("FAIL rd_dst1: got %h expected 007f", dstAt(1)); end
        clearInputs();
    endtask

    task automatic test_stack();
        clearInputs();
        bus.StackOp = 2'b01; bus.MemWrite = 1; bus.wr_data = 16'hBEEF;
        bus.MemSrc = 2'b10; bus.reg_in = 16'd1;
        launch(); tick();
        nChecks++; if (bus.sp_out !== 16'hFFFF) begin nFails++; $display("FAIL push_sp: got %h expected ffff", bus.sp_out); end
        tick();
        memRead(16'h03FF);
        nChecks++; if (bus.mem_out !== 16'hBEEF) begin nFails++; $display("FAIL push_ram3ff: got %h expected beef", bus.mem_out); end
        memRead(16'd1);
        nChecks++; if (bus.mem_out !== 16'd127) begin nFails++; $display("FAIL push_addr1_intact: got %h expected 007f", bus.mem_out); end
        clearInputs();
        bus.MemSrc = 2'b01; bus.MemRead = 1;
        launch(); tick(); tick();
        nChecks++; if (bus.mem_out !== 16'hBEEF || bus.sp_out !== 16'hFFFF) begin nFails++; $display("FAIL memsrc_sp_read: got mem_out=%h sp=%h expected beef ffff", bus.mem_out, bus.sp_out); end
        clearInputs();
        bus.StackOp = 2'b10; bus.MemRead = 1; bus.dst_en = 1; bus.MemDst = 2'd2;
        bus.MemSrc = 2'b10; bus.reg_in = 16'd1;
        launch(); tick();
        nChecks++; if (bus.mem_out !== 16'hBEEF || bus.sp_out !== 16'h0000) begin nFails++; $display("FAIL pop: got mem_out=%h sp=%h expected beef 0000", bus.mem_out, bus.sp_out); end
        tick();
        nChecks++; if (dstAt(2) !== 16'hBEEF) begin nFails++; $display("FAIL pop_dst2: got %h expected beef", dstAt(2)); end
        clearInputs();
    endtask

    task automatic test_read_write();
        memWrite(16'd5, 16'd3);
        clearInputs();
        bus.MemSrc = 2'b11; bus.reg_in = 16'd5; bus.MemRead = 1; bus.MemWrite = 1; bus.wr_data = 16'd9;
        launch(); tick();
        nChecks++; if (bus.mem_out !== 16'd3) begin nFails++; $display("FAIL rw_old_word: got %h expected 0003", bus.mem_out); end
        tick();
        memRead(16'd5);
        nChecks++; if (bus.mem_out !== 16'd9) begin nFails++; $display("FAIL rw_new_word: got %h expected 0009", bus.mem_out); end
    endtask

    task automatic test_busy_ignore();
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = 16'd5; bus.MemRead = 1;
        launch();
        bus.start = 1; bus.sp_load = 1; bus.sp_in = 16'h1234;
        tick();
        bus.start = 0; bus.sp_load = 0;
        doneCount = (bus.done === 1'b1) ? 1 : 0;
        nChecks++; if (bus.sp_out !== 16'h0000) begin nFails++; $display("FAIL busy_sp_load: got %h expected 0000", bus.sp_out); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.done === 1'b1) doneCount++;
        end
        nChecks++; if (doneCount !== 1) begin nFails++; $display("FAIL busy_done_pulses: got %0d expected 1", doneCount); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL busy_settles: got %b expected 0", bus.busy); end
        clearInputs();
        bus.sp_load = 1; bus.sp_in = 16'h0200;
        tick();
        bus.sp_load = 0;
        nChecks++; if (bus.sp_out !== 16'h0200) begin nFails++; $display("FAIL idle_sp_load: got %h expected 0200", bus.sp_out); end
        clearInputs();
        bus.StackOp = 2'b01; bus.MemWrite = 1; bus.wr_data = 16'hAAAA;
        bus.sp_load = 1; bus.sp_in = 16'h0300;
        launch();
        clearInputs();
        nChecks++; if (bus.sp_out !== 16'h0300) begin nFails++; $display("FAIL load_start_sp: got %h expected 0300", bus.sp_out); end
        tick();
        nChecks++; if (bus.sp_out !== 16'h02FF) begin nFails++; $display("FAIL load_start_push_sp: got %h expected 02ff", bus.sp_out); end
        tick();
        memRead(16'h01FF);
        nChecks++; if (bus.mem_out !== 16'hAAAA) begin nFails++; $display("FAIL load_start_addr: got %h expected aaaa", bus.mem_out); end
    endtask

    task automatic test_no_rw();
        clearInputs();
        bus.StackOp = 2'b01; bus.dst_en = 1; bus.MemDst = 2'd0;
        launch(); tick();
        nChecks++; if (bus.done !== 1'b1 || bus.sp_out !== 16'h02FE || bus.mem_out !== 16'hAAAA) begin nFails++; $display("FAIL norw_push: got done=%b sp=%h mem_out=%h expected 1 02fe aaaa", bus.done, bus.sp_out, bus.mem_out); end
        tick();
        nChecks++; if (dstAt(0) !== 16'h0000) begin nFails++; $display("FAIL norw_dst0: got %h expected 0000", dstAt(0)); end
        clearInputs();
        bus.StackOp = 2'b10;
        launch(); tick(); tick();
        nChecks++; if (bus.sp_out !== 16'h02FF) begin nFails++; $display("FAIL norw_pop: got %h expected 02ff", bus.sp_out); end
        clearInputs();
        bus.StackOp = 2'b11;
        launch(); tick(); tick();
        nChecks++; if (bus.sp_out !== 16'h02FF) begin nFails++; $display("FAIL stackop11: got %h expected 02ff", bus.sp_out); end
        clearInputs();
    endtask

    task automatic test_dw_collision();
        memWrite(16'd8, 16'h2222);
        bus.MemSrc = 2'b10; bus.reg_in = 16'd8; bus.MemRead = 1; bus.dst_en = 1; bus.MemDst = 2'd1;
        launch(); tick();
        clearInputs();
        bus.dw_en = 1; bus.dw_sel = 2'd1; bus.dw_data = 16'h1111;
        tick();
        bus.dw_en = 0;
        nChecks++; if (dstAt(1) !== 16'h2222) begin nFails++; $display("FAIL dw_collide_dst1: got %h expected 2222", dstAt(1)); end
        clearInputs();
        bus.MemSrc = 2'b10; bus.reg_in = 16'd8; bus.MemRead = 1; bus.dst_en = 1; bus.MemDst = 2'd1;
        launch(); tick();
        clearInputs();
        bus.dw_en = 1; bus.dw_sel = 2'd3; bus.dw_data = 16'h1111;
        tick();
        bus.dw_en = 0;
        nChecks++; if (dstAt(3) !== 16'h1111 || dstAt(1) !== 16'h2222) begin nFails++; $display("FAIL dw_split: got dst3=%h dst1=%h expected 1111 2222", dstAt(3), dstAt(1)); end
        bus.dw_en = 1; bus.dw_sel = 2'd0; bus.dw_data = 16'h0F0F;
        tick();
        bus.dw_en = 0;
        nChecks++; if (dstAt(0) !== 16'h0F0F || dstAt(2) !== 16'hBEEF) begin nFails++; $display("FAIL dw_idle: got dst0=%h dst2=%h expected 0f0f beef", dstAt(0), dstAt(2)); end
        clearInputs();
    endtask

    task automatic test_reset_mid();
        clearInputs();
        bus.MemSrc = 2'b00; bus.pc = 16'd7; bus.MemWrite = 1; bus.wr_data = 16'd4;
        launch(); tick(); tick();
        bus.wr_data = 16'd9; bus.StackOp = 2'b01;
        launch();
        reset = 1;
        tick();
        reset = 0;
        clearInputs();
        nChecks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nFails++; $display("FAIL rstmid_state: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        nChecks++; if (bus.sp_out !== 16'h0000 || bus.dst_out !== 64'h0) begin nFails++; $display("FAIL rstmid_regs: got sp=%h dst=%h expected 0000 0", bus.sp_out, bus.dst_out); end
        doneCount = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.done === 1'b1) doneCount++;
        end
        nChecks++; if (doneCount !== 0) begin nFails++; $display("FAIL rstmid_done: got %0d pulses expected 0", doneCount); end
        memRead(16'd7);
        nChecks++; if (bus.mem_out !== 16'd4) begin nFails++; $display("FAIL rstmid_ram7: got %h expected 0004", bus.mem_out); end
        memRead(16'h03FF);
        nChecks++; if (bus.mem_out !== 16'hBEEF) begin nFails++; $display("FAIL rstmid_ram3ff: got %h expected beef", bus.mem_out); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stack();
        test_read_write();
        test_busy_ignore();
        test_no_rw();
        test_dw_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
